// File: rtl/vga_fb_pkg.sv
// Shared timing constants, pixel/address types and the cell address helper
// for the 80x60 framebuffer scanout.
package vga_fb_pkg;
  localparam int H_VIS      = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_VIS      = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int H_TOT      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int COLS       = 80;
  localparam int ROWS       = 60;
  localparam int CELL_SHIFT = 3;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef logic [12:0] fb_addr_t;

  // row*80 as (row<<6)+(row<<4) so no multiplier is inferred
  function automatic fb_addr_t cell_addr(input logic [9:0] hc, input logic [9:0] vc);
    fb_addr_t row;
    fb_addr_t col;
    row = fb_addr_t'(vc >> CELL_SHIFT);
    col = fb_addr_t'(hc >> CELL_SHIFT);
    return (row << 6) + (row << 4) + col;
  endfunction
endpackage

// File: rtl/vga_fb_scanout_80x60_timing.sv
// Pixel tick divider plus raster counters; sync and visible are decoded
// combinationally from the counter registers.
module vga_timing_gen #(
  parameter int HVIS  = 640,
  parameter int HFP   = 16,
  parameter int HSYNC = 96,
  parameter int HBP   = 48,
  parameter int VVIS  = 480,
  parameter int VFP   = 10,
  parameter int VSYNC = 2,
  parameter int VBP   = 33
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_pix_en,
  output logic [9:0] o_hcnt,
  output logic [9:0] o_vcnt,
  output logic       o_visible,
  output logic       o_hsync_n,
  output logic       o_vsync_n
);
  localparam logic [9:0] H_LAST = 10'(HVIS + HFP + HSYNC + HBP - 1);
  localparam logic [9:0] V_LAST = 10'(VVIS + VFP + VSYNC + VBP - 1);
  localparam logic [9:0] HS_BEG = 10'(HVIS + HFP);
  localparam logic [9:0] HS_END = 10'(HVIS + HFP + HSYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(VVIS + VFP);
  localparam logic [9:0] VS_END = 10'(VVIS + VFP + VSYNC - 1);

  logic       r_pix_en;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_en <= 1'b0;
      r_hcnt   <= '0;
      r_vcnt   <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
    end
  end

  assign o_pix_en  = r_pix_en;
  assign o_hcnt    = r_hcnt;
  assign o_vcnt    = r_vcnt;
  assign o_visible = (r_hcnt < 10'(HVIS)) && (r_vcnt < 10'(VVIS));
  assign o_hsync_n = ~((r_hcnt >= HS_BEG) && (r_hcnt <= HS_END));
  assign o_vsync_n = ~((r_vcnt >= VS_BEG) && (r_vcnt <= VS_END));
endmodule

// File: rtl/vga_fb_scanout_80x60.sv
// Framebuffer scanout top: cell address generation and the output register
// stage that lines RGB up with the registered syncs.
module vga_fb_scanout_80x60 #(
  parameter int HVIS  = vga_fb_pkg::H_VIS,
  parameter int HFP   = vga_fb_pkg::H_FP,
  parameter int HSYNC = vga_fb_pkg::H_SYNC,
  parameter int HBP   = vga_fb_pkg::H_BP,
  parameter int VVIS  = vga_fb_pkg::V_VIS,
  parameter int VFP   = vga_fb_pkg::V_FP,
  parameter int VSYNC = vga_fb_pkg::V_SYNC,
  parameter int VBP   = vga_fb_pkg::V_BP
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [12:0] FB_RA,
  input  logic [7:0]  FB_RD,
  output logic [2:0]  ROUT,
  output logic [2:0]  GOUT,
  output logic [1:0]  BOUT,
  output logic        HS,
  output logic        VS,
  output logic        FRAME_START
);
  import vga_fb_pkg::*;

  logic       w_pix_en;
  logic [9:0] w_hcnt;
  logic [9:0] w_vcnt;
  logic       w_visible;
  logic       w_hsync_n;
  logic       w_vsync_n;

  vga_timing_gen #(
    .HVIS(HVIS), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP)
  ) u_timing (
    .i_clk     (CLK),
    .i_rst     (RST),
    .o_pix_en  (w_pix_en),
    .o_hcnt    (w_hcnt),
    .o_vcnt    (w_vcnt),
    .o_visible (w_visible),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n)
  );

  fb_addr_t w_ra;
  assign w_ra  = w_visible ? cell_addr(w_hcnt, w_vcnt) : '0;
  assign FB_RA = w_ra;

  rgb332_t r_rgb;
  logic    r_hs;
  logic    r_vs;
  logic    r_fs;

  // FB_RD here answers the address the counters have held since the last
  // tick, so registering against the same counters keeps RGB and syncs aligned
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_pix_en && (w_hcnt == 10'd0) && (w_vcnt == 10'd0);
      if (w_pix_en) begin
        r_rgb <= w_visible ? rgb332_t'(FB_RD) : '0;
        r_hs  <= w_hsync_n;
        r_vs  <= w_vsync_n;
      end
    end
  end

  assign ROUT        = r_rgb.r;
  assign GOUT        = r_rgb.g;
  assign BOUT        = r_rgb.b;
  assign HS          = r_hs;
  assign VS          = r_vs;
  assign FRAME_START = r_fs;
endmodule
